change_dispenser: RTL

//  Pays out a refund as physical coins. Takes the refund amount (cents) from the vending

---
 rtl/change_dispenser_pkg.sv | 35 +++
 rtl/change_dispenser_if.sv | 30 +++
 rtl/change_dispenser_ack_watchdog.sv | 30 +++
 rtl/change_dispenser.sv | 131 +++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin denominations, their
// one-hot bit positions, and the payout state encoding.
package change_dispenser_pkg;

  localparam int NUM_DENOM = 4;

  localparam int DENOM_20  = 20;
  localparam int DENOM_50  = 50;
  localparam int DENOM_100 = 100;
  localparam int DENOM_200 = 200;

  // Bit positions inside coin_sel, which is one-hot {200,100,50,20}
  localparam logic [1:0] COIN_IDX_20  = 2'd0;
  localparam logic [1:0] COIN_IDX_50  = 2'd1;
  localparam logic [1:0] COIN_IDX_100 = 2'd2;
  localparam logic [1:0] COIN_IDX_200 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_DISPENSE,
    ST_DONE,
    ST_FAULT
  } disp_state_e;

  function automatic int unsigned denom_value(input logic [1:0] idx);
    case (idx)
      COIN_IDX_20:  return DENOM_20;
      COIN_IDX_50:  return DENOM_50;
      COIN_IDX_100: return DENOM_100;
      default:      return DENOM_200;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Controller/hopper-facing bundle of the change dispenser. The dispenser is the
// slave; the vending controller plus coin hopper together act as master.
interface change_dispenser_if #(
  parameter int AMT_W = 11,
  parameter int INV_W = 8
);
  logic                 start;
  logic [AMT_W-1:0]     amount;
  logic                 refill;
  logic                 clear;
  logic                 coin_ack;
  logic                 coin_valid;
  logic [3:0]           coin_sel;
  logic                 busy;
  logic                 done;
  logic                 fault;
  logic [AMT_W-1:0]     residue;
  logic [7:0]           coins_out;
  logic [4*INV_W-1:0]   inv_level;   // per-denomination stock, 20-cent coins in the low byte

  modport master (
    output start, amount, refill, clear, coin_ack,
    input  coin_valid, coin_sel, busy, done, fault, residue, coins_out, inv_level
  );

  modport slave (
    input  start, amount, refill, clear, coin_ack,
    output coin_valid, coin_sel, busy, done, fault, residue, coins_out, inv_level
  );
endinterface

// File: rtl/change_dispenser_ack_watchdog.sv
// Counts cycles spent waiting for a hopper acknowledge and flags expiry once
// TIMEOUT_CYC waiting cycles have elapsed.
module ack_watchdog #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic arst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)              cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/change_dispenser.sv
// Refund payout engine: greedy largest-first coin selection over a valid/ack
// hopper handshake, with per-denomination inventory and residue reporting.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int TOTAL_AMOUNT = 800,
  parameter int INV_W        = 8,
  parameter int INV_INIT     = 20,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic           clk,
  input  logic           arst,
  change_dispenser_if.slave bus
);
  localparam int AMT_W = $clog2(TOTAL_AMOUNT) + 1;

  disp_state_e       state_q, state_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  logic [AMT_W-1:0]  residue_q, residue_d;
  logic [7:0]        coins_q, coins_d;
  logic [1:0]        sel_q, sel_d;
  logic [INV_W-1:0]  inv_q [NUM_DENOM];
  logic [INV_W-1:0]  inv_d [NUM_DENOM];

  logic              pick_ok;
  logic [1:0]        pick_idx;
  logic              in_dispense;
  logic              wd_expired;

  assign in_dispense = (state_q == ST_DISPENSE);

  ack_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ack_watchdog (
    .clk       (clk),
    .arst      (arst),
    .clear_i   (!in_dispense),
    .en_i      (in_dispense),
    .expired_o (wd_expired)
  );

  // Largest affordable denomination that still has stock; empty tubes are skipped.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = COIN_IDX_20;
    for (int i = NUM_DENOM - 1; i >= 0; i--) begin
      if (!pick_ok && inv_q[i] != '0 && rem_q >= AMT_W'(denom_value(2'(i)))) begin
        pick_ok  = 1'b1;
        pick_idx = 2'(i);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    residue_d = residue_q;
    coins_d   = coins_q;
    sel_d     = sel_q;
    inv_d     = inv_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          rem_d     = bus.amount;
          coins_d   = '0;
          residue_d = '0;
          state_d   = ST_SELECT;
        end else if (bus.refill) begin
          for (int i = 0; i < NUM_DENOM; i++) inv_d[i] = INV_W'(INV_INIT);
        end
      end
      ST_SELECT: begin
        if (pick_ok) begin
          sel_d   = pick_idx;
          state_d = ST_DISPENSE;
        end else begin
          residue_d = rem_q;
          state_d   = ST_DONE;
        end
      end
      ST_DISPENSE: begin
        if (bus.coin_ack) begin
          rem_d        = rem_q - AMT_W'(denom_value(sel_q));
          inv_d[sel_q] = inv_q[sel_q] - INV_W'(1);
          if (coins_q != 8'hFF) coins_d = coins_q + 8'd1;
          state_d      = ST_SELECT;
        end else if (wd_expired) begin
          residue_d = rem_q;
          state_d   = ST_FAULT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: if (bus.clear) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: the inventory array is reset explicitly because reset must restore a
  // known stock; it is a handful of flops, not a RAM macro.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      residue_q <= '0;
      coins_q   <= '0;
      sel_q     <= COIN_IDX_20;
      for (int i = 0; i < NUM_DENOM; i++) inv_q[i] <= INV_W'(INV_INIT);
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      residue_q <= residue_d;
      coins_q   <= coins_d;
      sel_q     <= sel_d;
      inv_q     <= inv_d;
    end
  end

  assign bus.coin_valid = in_dispense;
  assign bus.coin_sel   = in_dispense ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.fault      = (state_q == ST_FAULT);
  assign bus.residue    = residue_q;
  assign bus.coins_out  = coins_q;

  always_comb begin
    bus.inv_level = '0;
    for (int i = 0; i < NUM_DENOM; i++) bus.inv_level[i*INV_W +: INV_W] = inv_q[i];
  end
endmodule
